// File: rtl/block_merge_buffer_if.sv
// Handshake/bus bundle between the cache controller and the line merge buffer.
// The master side drives requests; the buffer attaches through the slave modport.
interface block_merge_buffer_if #(
    parameter int WORD_SIZE        = 32,
    parameter int BLOCK_SIZE       = 512,
    parameter int NUM_SEGMENTS_LOG = 4,
    parameter int BEAT_SIZE        = 128
);
    localparam int NUM_BYTES  = BLOCK_SIZE / 8;
    localparam int WORD_BYTES = WORD_SIZE / 8;

    logic                        load_valid;
    logic [BLOCK_SIZE-1:0]       load_data;
    logic                        fill_start;
    logic                        beat_valid;
    logic [BEAT_SIZE-1:0]        beat_data;
    logic                        beat_ready;
    logic                        wr_valid;
    logic                        wr_ready;
    logic [NUM_SEGMENTS_LOG-1:0] wr_offset;
    logic [WORD_SIZE-1:0]        wr_data;
    logic [WORD_BYTES-1:0]       wr_byte_en;
    logic                        flush;
    logic                        out_valid;
    logic                        out_ready;
    logic [BLOCK_SIZE-1:0]       out_data;
    logic [NUM_BYTES-1:0]        out_mask;
    logic                        busy;

    modport master (
        output load_valid, load_data, fill_start, beat_valid, beat_data,
               wr_valid, wr_offset, wr_data, wr_byte_en, flush, out_ready,
        input  beat_ready, wr_ready, out_valid, out_data, out_mask, busy
    );

    modport slave (
        input  load_valid, load_data, fill_start, beat_valid, beat_data,
               wr_valid, wr_offset, wr_data, wr_byte_en, flush, out_ready,
        output beat_ready, wr_ready, out_valid, out_data, out_mask, busy
    );
endinterface

// File: rtl/block_merge_buffer.sv
// Single-line staging buffer: sources a line by load or multi-beat refill, merges
// byte-enabled CPU writes into it, and hands the line plus written-byte mask out.
module block_merge_buffer #(
    parameter int WORD_SIZE        = 32,
    parameter int BLOCK_SIZE       = 512,
    parameter int NUM_SEGMENTS     = 16,
    parameter int NUM_SEGMENTS_LOG = 4,
    parameter int BEAT_SIZE        = 128
) (
    input logic clk,
    input logic rst,
    block_merge_buffer_if.slave bus
);
    localparam int NUM_BEATS  = BLOCK_SIZE / BEAT_SIZE;
    localparam int NUM_BYTES  = BLOCK_SIZE / 8;
    localparam int WORD_BYTES = WORD_SIZE / 8;
    localparam int BEAT_BYTES = BEAT_SIZE / 8;
    localparam int CNT_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD,
        OUT
    } state_t;

    state_t                r_state;
    logic [BLOCK_SIZE-1:0] r_line;
    logic [NUM_BYTES-1:0]  r_mask;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_wr_fire;
    logic                  w_beat_fire;
    logic                  w_last_beat;
    logic [BLOCK_SIZE-1:0] w_line_nxt;
    logic [NUM_BYTES-1:0]  w_mask_nxt;

    assign bus.beat_ready = (r_state == FILL);
    assign bus.wr_ready   = (r_state == FILL) || (r_state == HOLD);
    assign bus.out_valid  = (r_state == OUT);
    assign bus.busy       = (r_state != IDLE);
    assign bus.out_data   = r_line;
    assign bus.out_mask   = r_mask;

    assign w_wr_fire   = bus.wr_valid && bus.wr_ready;
    assign w_beat_fire = bus.beat_valid && bus.beat_ready;
    assign w_last_beat = (r_cnt == CNT_W'(NUM_BEATS - 1));

    // Beat bytes land only where the CPU has not written; a same-cycle CPU
    // write is applied afterwards so it overrides the beat on the same byte.
    always_comb begin
        w_line_nxt = r_line;
        w_mask_nxt = r_mask;
        for (int unsigned bt = 0; bt < NUM_BEATS; bt++) begin
            for (int unsigned j = 0; j < BEAT_BYTES; j++) begin
                if (w_beat_fire && (32'(r_cnt) == bt) && !r_mask[bt*BEAT_BYTES + j]) begin
                    w_line_nxt[(bt*BEAT_BYTES + j)*8 +: 8] = bus.beat_data[j*8 +: 8];
                end
            end
        end
        for (int unsigned w = 0; w < NUM_SEGMENTS; w++) begin
            for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                if (w_wr_fire && (32'(bus.wr_offset) == w) && bus.wr_byte_en[i]) begin
                    w_line_nxt[w*WORD_SIZE + i*8 +: 8] = bus.wr_data[i*8 +: 8];
                    w_mask_nxt[w*WORD_BYTES + i]       = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_line  <= '0;
            r_mask  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.load_valid) begin
                        r_line  <= bus.load_data;
                        r_mask  <= '0;
                        r_state <= HOLD;
                    end else if (bus.fill_start) begin
                        r_mask  <= '0;
                        r_cnt   <= '0;
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    r_line <= w_line_nxt;
                    r_mask <= w_mask_nxt;
                    if (w_beat_fire) begin
                        if (w_last_beat) begin
                            r_cnt   <= '0;
                            r_state <= HOLD;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    r_line <= w_line_nxt;
                    r_mask <= w_mask_nxt;
                    if (bus.flush) begin
                        r_state <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_mask  <= '0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_block_merge_buffer.sv
// Directed bench for block_merge_buffer: flushed lines are checked by a scoreboard
// monitor against hand-built expected line/mask pairs queued at flush time.
module tb_block_merge_buffer;
    localparam int BLOCK_SIZE = 512;
    localparam int BEAT_SIZE  = 128;
    localparam int NUM_BYTES  = 64;

    typedef struct {
        logic [BLOCK_SIZE-1:0] data;
        logic [NUM_BYTES-1:0]  mask;
    } exp_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    exp_t sb[$];

    logic [BLOCK_SIZE-1:0] line_k;
    logic [BLOCK_SIZE-1:0] e_data;
    logic [NUM_BYTES-1:0]  e_mask;

    block_merge_buffer_if #(
        .WORD_SIZE(32), .BLOCK_SIZE(BLOCK_SIZE), .NUM_SEGMENTS_LOG(4), .BEAT_SIZE(BEAT_SIZE)
    ) bus ();

    block_merge_buffer #(
        .WORD_SIZE(32), .BLOCK_SIZE(BLOCK_SIZE), .NUM_SEGMENTS(16),
        .NUM_SEGMENTS_LOG(4), .BEAT_SIZE(BEAT_SIZE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic ok,
                                  input logic [BLOCK_SIZE-1:0] act,
                                  input logic [BLOCK_SIZE-1:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endfunction

    // Scoreboard monitor: every accepted output line is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 1'b0, bus.out_data, '0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", bus.out_data == e.data, bus.out_data, e.data);
                check("out_mask", bus.out_mask == e.mask,
                      BLOCK_SIZE'(bus.out_mask), BLOCK_SIZE'(e.mask));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [BLOCK_SIZE-1:0] d, input logic [NUM_BYTES-1:0] m);
        exp_t e;
        e.data = d;
        e.mask = m;
        sb.push_back(e);
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb.size() == 0, BLOCK_SIZE'(sb.size()), '0);
        step();
    endtask

    task automatic do_load(input logic [BLOCK_SIZE-1:0] d);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        step();
        bus.load_valid = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] en);
        bus.wr_valid   = 1'b1;
        bus.wr_offset  = off;
        bus.wr_data    = d;
        bus.wr_byte_en = en;
        step();
        bus.wr_valid   = 1'b0;
    endtask

    task automatic do_beat(input logic [7:0] b);
        bus.beat_valid = 1'b1;
        bus.beat_data  = {16{b}};
        step();
        bus.beat_valid = 1'b0;
    endtask

    task automatic do_flush(input logic [BLOCK_SIZE-1:0] d, input logic [NUM_BYTES-1:0] m);
        push_exp(d, m);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        bus.load_valid = 1'b0; bus.load_data = '0; bus.fill_start = 1'b0;
        bus.beat_valid = 1'b0; bus.beat_data = '0; bus.wr_valid = 1'b0;
        bus.wr_offset = '0; bus.wr_data = '0; bus.wr_byte_en = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        for (int k = 0; k < NUM_BYTES; k++) line_k[k*8 +: 8] = 8'(k);

        // Reset state
        step(); step();
        @(negedge clk);
        check("rst_ctrl", {bus.beat_ready, bus.wr_ready, bus.out_valid, bus.busy} == 4'b0,
              BLOCK_SIZE'({bus.beat_ready, bus.wr_ready, bus.out_valid, bus.busy}), '0);
        check("rst_data", bus.out_data == '0, bus.out_data, '0);
        check("rst_mask", bus.out_mask == '0, BLOCK_SIZE'(bus.out_mask), '0);
        step();
        rst = 1'b0;

        // Load then flush unchanged
        do_load(line_k);
        do_flush(line_k, '0);
        @(negedge clk);
        check("busy_after_out", bus.busy == 1'b0, BLOCK_SIZE'(bus.busy), '0);
        step();

        // Byte-masked write, then a zero-enable no-op write
        do_load(line_k);
        do_write(4'd5, 32'hDEADBEEF, 4'b0101);
        do_write(4'd6, 32'hFFFFFFFF, 4'b0000);
        e_data = line_k;
        e_data[20*8 +: 8] = 8'hEF;
        e_data[22*8 +: 8] = 8'hAD;
        e_mask = '0;
        e_mask[20] = 1'b1;
        e_mask[22] = 1'b1;
        do_flush(e_data, e_mask);

        // Write in the same cycle as flush lands before OUT (last byte of line)
        do_load(line_k);
        bus.wr_valid = 1'b1; bus.wr_offset = 4'd15; bus.wr_data = 32'h77000000;
        bus.wr_byte_en = 4'b1000;
        e_data = line_k;
        e_data[63*8 +: 8] = 8'h77;
        e_mask = '0;
        e_mask[63] = 1'b1;
        push_exp(e_data, e_mask);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0; bus.wr_valid = 1'b0;
        drain();

        // Refill with CPU write before the first beat
        bus.fill_start = 1'b1;
        step();
        bus.fill_start = 1'b0;
        do_write(4'd0, 32'h11223344, 4'hF);
        do_beat(8'hAA); do_beat(8'hAA); do_beat(8'hAA);
        @(negedge clk);
        check("fill_3beats_still_fill", bus.beat_ready == 1'b1, BLOCK_SIZE'(bus.beat_ready), 1);
        step();
        do_beat(8'hAA);
        @(negedge clk);
        check("fill_done_hold", {bus.beat_ready, bus.wr_ready, bus.busy} == 3'b011,
              BLOCK_SIZE'({bus.beat_ready, bus.wr_ready, bus.busy}), 3);
        step();
        e_data = {BLOCK_SIZE/8{8'hAA}};
        e_data[31:0] = 32'h11223344;
        e_mask = '0;
        e_mask[3:0] = 4'hF;
        do_flush(e_data, e_mask);

        // Same-cycle beat and write on the same bytes
        bus.fill_start = 1'b1;
        step();
        bus.fill_start = 1'b0;
        do_beat(8'h33);
        bus.wr_valid = 1'b1; bus.wr_offset = 4'd4; bus.wr_data = 32'h0; bus.wr_byte_en = 4'hF;
        do_beat(8'h55);
        bus.wr_valid = 1'b0;
        do_beat(8'h66); do_beat(8'h66);
        e_data = {{32{8'h66}}, {12{8'h55}}, 32'h0, {16{8'h33}}};
        e_mask = '0;
        e_mask[19:16] = 4'hF;
        do_flush(e_data, e_mask);

        // Output backpressure with writes attempted in OUT
        bus.out_ready = 1'b0;
        do_load(line_k);
        push_exp(line_k, '0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_offset = 4'd2; bus.wr_data = 32'hCAFEF00D; bus.wr_byte_en = 4'hF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", bus.out_valid == 1'b1, BLOCK_SIZE'(bus.out_valid), 1);
            check("bp_data_stable", bus.out_data == line_k, bus.out_data, line_k);
            check("bp_wr_ready", bus.wr_ready == 1'b0, BLOCK_SIZE'(bus.wr_ready), 0);
            step();
        end
        bus.wr_valid = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        // Reset mid-fill, then a fresh fill restarts at beat 0
        bus.fill_start = 1'b1;
        step();
        bus.fill_start = 1'b0;
        do_beat(8'hBB); do_beat(8'hBB);
        rst = 1'b1;
        step();
        @(negedge clk);
        check("midfill_rst_busy", {bus.busy, bus.beat_ready} == 2'b00,
              BLOCK_SIZE'({bus.busy, bus.beat_ready}), 0);
        check("midfill_rst_line", bus.out_data == '0, bus.out_data, '0);
        step();
        rst = 1'b0;
        bus.fill_start = 1'b1;
        step();
        bus.fill_start = 1'b0;
        do_beat(8'hC0); do_beat(8'hC1); do_beat(8'hC2); do_beat(8'hC3);
        e_data = {{16{8'hC3}}, {16{8'hC2}}, {16{8'hC1}}, {16{8'hC0}}};
        do_flush(e_data, '0);

        check("sb_empty", sb.size() == 0, BLOCK_SIZE'(sb.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/block_merge_buffer.md
Name: block_merge_buffer

Overview:
- Single-line staging buffer for the cache controller. Holds one BLOCK_SIZE line and merges CPU word writes with byte enables into it.
- The line is sourced either from a one-cycle load (cache hit path) or from a multi-beat memory refill (miss path). During a refill, CPU writes are accepted and must not be overwritten by later refill beats.
- On flush, the merged line and its per-byte written mask are presented with a valid/ready handshake to the cache data array or to the write-back path.

Parameters:
- WORD_SIZE, 32, bits per CPU word.
- BLOCK_SIZE, 512, bits per cache line.
- NUM_SEGMENTS, 16, words per line (BLOCK_SIZE/WORD_SIZE).
- NUM_SEGMENTS_LOG, 4, log2(NUM_SEGMENTS).
- BEAT_SIZE, 128, bits per memory refill beat. BLOCK_SIZE must be a multiple of BEAT_SIZE.
- Derived localparams:
  - NUM_BEATS = BLOCK_SIZE/BEAT_SIZE.
  - NUM_BYTES = BLOCK_SIZE/8.
  - WORD_BYTES = WORD_SIZE/8.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  capture load_data as the full line. Accepted only in IDLE.
- load_data  in  BLOCK_SIZE  line from the cache data array.
- fill_start  in  1  begin a memory refill. Accepted only in IDLE.
- beat_valid  in  1  refill beat present.
- beat_data  in  BEAT_SIZE  refill beat payload. Beats arrive in order, lowest address first.
- beat_ready  out  1  beat accepted this cycle.
- wr_valid  in  1  CPU write request.
- wr_ready  out  1  CPU write accepted this cycle.
- wr_offset  in  NUM_SEGMENTS_LOG  word index within the line.
- wr_data  in  WORD_SIZE  write data.
- wr_byte_en  in  WORD_BYTES  per-byte write enable.
- flush  in  1  request output of the line. Honoured in HOLD only.
- out_valid  out  1  merged line available.
- out_ready  in  1  consumer accepts the line.
- out_data  out  BLOCK_SIZE  merged line.
- out_mask  out  NUM_BYTES  bytes written by the CPU since the line was sourced.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE; line, mask and beat counter cleared to 0. All outputs are 0: beat_ready, wr_ready, out_valid, busy, out_data, out_mask.
- Reset asserted mid-FILL or mid-OUT aborts the operation immediately. No handshake completes in that cycle.
- IDLE:
  - load_valid has priority over fill_start.
  - On load_valid: line <= load_data, mask <= 0, state -> HOLD.
  - On fill_start alone: mask <= 0, beat counter <= 0, state -> FILL.
  - wr_ready=0 and beat_ready=0.
- FILL:
  - beat_ready=1 and wr_ready=1.
  - On beat_valid: segment [cnt*BEAT_SIZE +: BEAT_SIZE] is updated byte-by-byte, but only for bytes whose mask bit is 0. cnt then increments.
  - On the beat with cnt==NUM_BEATS-1: cnt wraps to 0 and state -> HOLD in the next cycle.
  - A CPU write and a beat in the same cycle, covering the same byte: the CPU value wins and the mask bit is set.
  - flush is ignored in FILL.
- HOLD:
  - wr_ready=1 and beat_ready=0.
  - On wr_valid: for each i with wr_byte_en[i]=1, byte i of word wr_offset <= wr_data byte i, and the corresponding mask bit <= 1.
  - wr_byte_en=0 is accepted as a no-op.
  - flush -> OUT. A write in the same cycle as flush is applied before entering OUT.
- OUT:
  - out_valid=1; out_data and out_mask reflect the registered line and mask.
  - wr_ready=0 and beat_ready=0.
  - out_data and out_mask are held stable while out_ready=0.
  - On out_ready: state -> IDLE, out_valid=0 next cycle.
  - The line is retained but mask is cleared on exit.
- Latency:
  - A write is visible in out_data one cycle after acceptance.
  - load to out_valid takes at least 2 cycles (load, flush).
  - Refill takes exactly NUM_BEATS accepted beats.
- Registered state is line, mask, cnt and state only. All outputs are derived from registers or from state decode. There are no combinational paths from inputs to outputs except none; beat_ready and wr_ready depend on state only.

Test Plan:
- Reset then load: rst=1 for 2 cycles → all outputs 0. Then load_valid with line of byte k = k (0x00..0x3F), flush, out_ready=1 → out_data equals input, out_mask=0, busy drops after handshake.
- Byte-masked write in HOLD: after the load above, write wr_offset=5, wr_data=0xDEADBEEF, wr_byte_en=4'b0101, then flush → bytes 20 and 22 become 0xEF and 0xAD, bytes 21 and 23 unchanged (0x15, 0x17). out_mask has only bits 20 and 22 set.
- Refill with interleaved write: fill_start, then write word 0 = 0x11223344 with en=4'hF before beat 0. Feed beats of all-0xAA → word 0 is 0x11223344 and the rest is 0xAA. State reaches HOLD after the 4th beat.
- Same-cycle collision: in FILL at cnt=1, beat 0x55.. and write wr_offset=4, en=4'hF, data=0x0 in the same cycle → word 4 is 0x00000000, words 5-7 are 0x55555555.
- Output backpressure: in OUT, hold out_ready=0 for 5 cycles while driving wr_valid=1 → out_valid stays 1, out_data is unchanged, wr_ready=0 throughout.
- Reset mid-fill: rst after 2 of 4 beats → IDLE the next cycle, line 0, busy=0. A fresh fill_start restarts at cnt=0.
